// File: rtl/axis_red_pitaya_prbs_corr.sv
// Receive-side PRBS correlator: delays the transmitted chip/flag stream and accumulates
// sign-weighted ADC samples per burst. Define PRBS_CORR_SAT_EN for saturating accumulators.
module axis_red_pitaya_prbs_corr #(
    parameter int ACC_WIDTH   = 32,
    parameter int DELAY_DEPTH = 64
) (
    input  logic                     aclk,
    input  logic                     srst,
    input  logic [31:0]              s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     lfsr_sig_i,
    input  logic                     tx_flag_i,
    input  logic [31:0]              rx_cfg_i,
    output logic [2*ACC_WIDTH-1:0]   m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [31:0]              cnt_o,
    output logic                     ovr_o
);

    localparam int DW  = $clog2(DELAY_DEPTH);
    localparam int EXT = ACC_WIDTH + 1 - 14;
    localparam logic [ACC_WIDTH-1:0] ACC_ZERO = {ACC_WIDTH{1'b0}};
    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACC = 1'b1} state_t;

    state_t                 state_r, state_nx_s;
    logic [1:0]             dly_r [DELAY_DEPTH];
    logic [1:0]             tap_s;
    logic [DW-1:0]          tap_idx_s;
    logic                   flag_d_s, chip_d_s, enable_s, clear_ovr_s;
    logic                   acc_en_s, burst_start_s, load_s;
    logic [ACC_WIDTH-1:0]   acc_a_r, acc_b_r, acc_a_base_s, acc_b_base_s;
    logic                   sat_a_r, sat_b_r, sat_a_base_s, sat_b_base_s;
    logic [ACC_WIDTH:0]     a_ext_s, b_ext_s, upd_a_s, upd_b_s;
    logic [31:0]            cnt_r, cnt_base_s, cnt_nx_s;
    logic                   cfg_unused_s;

    // One accumulator step; returns {sticky_saturated, new_value}.
    function automatic logic [ACC_WIDTH:0] acc_update(input logic [ACC_WIDTH-1:0] acc,
                                                      input logic sat,
                                                      input logic [ACC_WIDTH:0] x,
                                                      input logic add);
        logic [ACC_WIDTH:0] sum;
        sum = add ? ({acc[ACC_WIDTH-1], acc} + x) : ({acc[ACC_WIDTH-1], acc} - x);
`ifdef PRBS_CORR_SAT_EN
        if (sat) begin
            return {1'b1, acc};
        end else if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            return {1'b1, (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX)};
        end else begin
            return {1'b0, sum[ACC_WIDTH-1:0]};
        end
`else
        return {sat, sum[ACC_WIDTH-1:0]};
`endif
    endfunction

    assign s_axis_tready = 1'b1;
    assign enable_s      = rx_cfg_i[8];
    assign clear_ovr_s   = rx_cfg_i[9];
    assign cfg_unused_s  = ^{rx_cfg_i[31:10], s_axis_tdata[31:30], s_axis_tdata[15:14]};
    assign a_ext_s       = {{EXT{s_axis_tdata[13]}}, s_axis_tdata[13:0]};
    assign b_ext_s       = {{EXT{s_axis_tdata[29]}}, s_axis_tdata[29:16]};
    assign tap_idx_s     = DW'(rx_cfg_i[7:0] - 8'd1);

    // Chip/flag history shift register; entry k holds the inputs from k+1 cycles ago.
    always_ff @(posedge aclk) begin
        if (srst) begin
            for (int k = 0; k < DELAY_DEPTH; k++) begin
                dly_r[k] <= 2'b00;
            end
        end else begin
            dly_r[0] <= {tx_flag_i, lfsr_sig_i};
            for (int k = 1; k < DELAY_DEPTH; k++) begin
                dly_r[k] <= dly_r[k-1];
            end
        end
    end

    // Delay tap: D=0 bypasses the history, out-of-range delays read as idle.
    always_comb begin
        tap_s = 2'b00;
        if (rx_cfg_i[7:0] == 8'd0) begin
            tap_s = {tx_flag_i, lfsr_sig_i};
        end else if (int'(rx_cfg_i[7:0]) < DELAY_DEPTH) begin
            tap_s = dly_r[tap_idx_s];
        end else begin
            tap_s = 2'b00;
        end
    end

    assign flag_d_s = tap_s[1];
    assign chip_d_s = tap_s[0];

    // Burst FSM next-state and control strobes; an abort beats a falling flag.
    always_comb begin
        state_nx_s    = state_r;
        acc_en_s      = 1'b0;
        burst_start_s = 1'b0;
        load_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (flag_d_s && enable_s) begin
                    state_nx_s    = ST_ACC;
                    acc_en_s      = 1'b1;
                    burst_start_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (!enable_s) begin
                    state_nx_s = ST_IDLE;
                end else if (flag_d_s) begin
                    acc_en_s = 1'b1;
                end else begin
                    load_s     = 1'b1;
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (srst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    assign acc_a_base_s = burst_start_s ? ACC_ZERO : acc_a_r;
    assign acc_b_base_s = burst_start_s ? ACC_ZERO : acc_b_r;
    assign sat_a_base_s = burst_start_s ? 1'b0 : sat_a_r;
    assign sat_b_base_s = burst_start_s ? 1'b0 : sat_b_r;
    assign cnt_base_s   = burst_start_s ? 32'd0 : cnt_r;
    assign upd_a_s      = acc_update(acc_a_base_s, sat_a_base_s, a_ext_s, chip_d_s);
    assign upd_b_s      = acc_update(acc_b_base_s, sat_b_base_s, b_ext_s, chip_d_s);
    assign cnt_nx_s     = (cnt_base_s == 32'hFFFF_FFFF) ? cnt_base_s : cnt_base_s + 32'd1;

    // Per-burst accumulators and sample count; a burst start restarts them from zero.
    always_ff @(posedge aclk) begin
        if (srst) begin
            acc_a_r <= ACC_ZERO;
            acc_b_r <= ACC_ZERO;
            sat_a_r <= 1'b0;
            sat_b_r <= 1'b0;
            cnt_r   <= 32'd0;
        end else if (acc_en_s && s_axis_tvalid) begin
            acc_a_r <= upd_a_s[ACC_WIDTH-1:0];
            acc_b_r <= upd_b_s[ACC_WIDTH-1:0];
            sat_a_r <= upd_a_s[ACC_WIDTH];
            sat_b_r <= upd_b_s[ACC_WIDTH];
            cnt_r   <= cnt_nx_s;
        end else if (burst_start_s) begin
            acc_a_r <= ACC_ZERO;
            acc_b_r <= ACC_ZERO;
            sat_a_r <= 1'b0;
            sat_b_r <= 1'b0;
            cnt_r   <= 32'd0;
        end
    end

    // Result register, valid handshake and sticky overrun flag.
    always_ff @(posedge aclk) begin
        if (srst) begin
            m_axis_tdata  <= {(2*ACC_WIDTH){1'b0}};
            cnt_o         <= 32'd0;
            m_axis_tvalid <= 1'b0;
            ovr_o         <= 1'b0;
        end else begin
            if (load_s) begin
                m_axis_tdata <= {acc_b_r, acc_a_r};
                cnt_o        <= cnt_r;
            end
            if (load_s) begin
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (load_s && m_axis_tvalid && !m_axis_tready) begin
                ovr_o <= 1'b1;
            end else if (clear_ovr_s) begin
                ovr_o <= 1'b0;
            end
        end
    end

endmodule
